// File: rtl/ps2_mouse_decoder.sv
// ps2_mouse_decoder
//   Receive-only PS/2 mouse front end. Synchronises the raw PS/2 clock and
//   data lines, deframes 11-bit frames (start, 8 data LSB first, odd parity,
//   stop), assembles 3-byte stream-mode packets and integrates the movement
//   into clamped absolute cursor coordinates plus button levels.
//
// Ports
//   CLK_50MHZ  in   system clock
//   MASTER_RST in   asynchronous active-low reset
//   PS2_CLK    in   raw PS/2 clock (asynchronous to CLK_50MHZ)
//   PS2_DATA   in   raw PS/2 data  (asynchronous to CLK_50MHZ)
//   XCOORD     out  cursor X, 0..X_MAX
//   YCOORD     out  cursor Y, 0..Y_MAX, 0 = top of screen
//   L_BUTTON   out  left button level
//   R_BUTTON   out  right button level
//   M_BUTTON   out  middle button level
//   PKT_VALID  out  one-cycle pulse when a packet updates the outputs
//   FRAME_ERR  out  one-cycle pulse on start/parity/stop error or timeout
module ps2_mouse_decoder #(
  parameter int X_MAX   = 639,
  parameter int Y_MAX   = 479,
  parameter int X_INIT  = 320,
  parameter int Y_INIT  = 240,
  parameter int TIMEOUT = 50000
) (
  input  logic        CLK_50MHZ,
  input  logic        MASTER_RST,
  input  logic        PS2_CLK,
  input  logic        PS2_DATA,
  output logic [11:0] XCOORD,
  output logic [11:0] YCOORD,
  output logic        L_BUTTON,
  output logic        R_BUTTON,
  output logic        M_BUTTON,
  output logic        PKT_VALID,
  output logic        FRAME_ERR
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT);
  localparam logic signed [13:0] X_MAX_S = 14'(X_MAX);
  localparam logic signed [13:0] Y_MAX_S = 14'(Y_MAX);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers. clk_sync_reg[1] is the synchronised clock and
  // clk_sync_reg[2] its previous value, so data_sync_reg[1] lines up with
  // clk_sync_reg[1] for sampling.
  // ---------------------------------------------------------------------------
  logic [2:0] clk_sync_reg;
  logic [1:0] data_sync_reg;
  logic       ps2_fall;
  logic       ps2_data;

  always_ff @(posedge CLK_50MHZ or negedge MASTER_RST) begin
    if (!MASTER_RST) begin
      clk_sync_reg  <= 3'b111;
      data_sync_reg <= 2'b11;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[1:0], PS2_CLK};
      data_sync_reg <= {data_sync_reg[0], PS2_DATA};
    end
  end

  assign ps2_fall = clk_sync_reg[2] & ~clk_sync_reg[1];
  assign ps2_data = data_sync_reg[1];

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  frame_state_t state_reg, state_next;
  logic [2:0]   bit_cnt_reg;
  logic [7:0]   shift_reg;
  logic         parity_reg;
  logic [7:0]   rx_byte_reg;
  logic         byte_valid_reg;
  logic         byte_err_reg;

  logic start_ok, start_err, shift_en, parity_en, stop_en;
  logic byte_good, byte_done_good, byte_done_bad;

  logic [TO_W-1:0] to_cnt_reg;
  logic            to_active;
  logic            timeout_hit;

  logic [1:0]      pkt_idx_reg;

  // State register
  always_ff @(posedge CLK_50MHZ or negedge MASTER_RST) begin
    if (!MASTER_RST) state_reg <= ST_IDLE;
    else             state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (timeout_hit) begin
      state_next = ST_IDLE;
    end else if (ps2_fall) begin
      case (state_reg)
        ST_IDLE:   if (!ps2_data) state_next = ST_DATA;
        ST_DATA:   if (bit_cnt_reg == 3'd7) state_next = ST_PARITY;
        ST_PARITY: state_next = ST_STOP;
        ST_STOP:   state_next = ST_IDLE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  // Output logic: per-edge strobes for the frame datapath
  always_comb begin
    start_ok  = 1'b0;
    start_err = 1'b0;
    shift_en  = 1'b0;
    parity_en = 1'b0;
    stop_en   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        start_ok  = ps2_fall & ~ps2_data;
        start_err = ps2_fall &  ps2_data;
      end
      ST_DATA:   shift_en  = ps2_fall;
      ST_PARITY: parity_en = ps2_fall;
      ST_STOP:   stop_en   = ps2_fall;
      default: ;
    endcase
    // Odd parity: data bits plus parity bit must XOR to 1; stop bit must be 1.
    byte_good      = ps2_data & (^{shift_reg, parity_reg});
    byte_done_good = stop_en & byte_good;
    byte_done_bad  = stop_en & ~byte_good;
  end

  // Frame datapath
  always_ff @(posedge CLK_50MHZ or negedge MASTER_RST) begin
    if (!MASTER_RST) begin
      bit_cnt_reg    <= 3'd0;
      shift_reg      <= 8'd0;
      parity_reg     <= 1'b0;
      rx_byte_reg    <= 8'd0;
      byte_valid_reg <= 1'b0;
      byte_err_reg   <= 1'b0;
    end else begin
      if (start_ok)      bit_cnt_reg <= 3'd0;
      else if (shift_en) bit_cnt_reg <= bit_cnt_reg + 3'd1;
      if (shift_en)       shift_reg   <= {ps2_data, shift_reg[7:1]};
      if (parity_en)      parity_reg  <= ps2_data;
      if (byte_done_good) rx_byte_reg <= shift_reg;
      byte_valid_reg <= byte_done_good;
      byte_err_reg   <= byte_done_bad;
    end
  end

  // ---------------------------------------------------------------------------
  // Inactivity timeout: armed while a frame or a packet is partly received.
  // ---------------------------------------------------------------------------
  assign to_active   = (state_reg != ST_IDLE) || (pkt_idx_reg != 2'd0);
  assign timeout_hit = to_active && !ps2_fall && (to_cnt_reg == TO_MAX);

  always_ff @(posedge CLK_50MHZ or negedge MASTER_RST) begin
    if (!MASTER_RST)                              to_cnt_reg <= '0;
    else if (ps2_fall || timeout_hit || !to_active) to_cnt_reg <= '0;
    else                                           to_cnt_reg <= to_cnt_reg + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Packet assembler. Only the header fields that matter are kept.
  // ---------------------------------------------------------------------------
  logic [2:0] btn_pend_reg;
  logic       x_sign_reg, y_sign_reg, x_ovf_reg, y_ovf_reg;
  logic [7:0] dx_raw_reg;
  logic       pkt_apply;

  always_ff @(posedge CLK_50MHZ or negedge MASTER_RST) begin
    if (!MASTER_RST) begin
      pkt_idx_reg  <= 2'd0;
      btn_pend_reg <= 3'd0;
      x_sign_reg   <= 1'b0;
      y_sign_reg   <= 1'b0;
      x_ovf_reg    <= 1'b0;
      y_ovf_reg    <= 1'b0;
      dx_raw_reg   <= 8'd0;
    end else if (timeout_hit || byte_err_reg) begin
      pkt_idx_reg <= 2'd0;
    end else if (byte_valid_reg) begin
      case (pkt_idx_reg)
        2'd0: begin
          // Header must have bit3 set; 0xFA is a command ACK, not a header.
          if (rx_byte_reg[3] && rx_byte_reg != 8'hFA) begin
            btn_pend_reg <= rx_byte_reg[2:0];
            x_sign_reg   <= rx_byte_reg[4];
            y_sign_reg   <= rx_byte_reg[5];
            x_ovf_reg    <= rx_byte_reg[6];
            y_ovf_reg    <= rx_byte_reg[7];
            pkt_idx_reg  <= 2'd1;
          end
        end
        2'd1: begin
          dx_raw_reg  <= rx_byte_reg;
          pkt_idx_reg <= 2'd2;
        end
        default: pkt_idx_reg <= 2'd0;
      endcase
    end
  end

  assign pkt_apply = byte_valid_reg && (pkt_idx_reg == 2'd2) &&
                     !timeout_hit && !byte_err_reg;

  // ---------------------------------------------------------------------------
  // Coordinate integration. The third byte is used straight from rx_byte_reg
  // so the outputs land one cycle after it is accepted.
  // ---------------------------------------------------------------------------
  logic [11:0] x_reg, y_reg;
  logic        l_reg, r_reg, m_reg, pkt_valid_reg, frame_err_reg;
  logic [8:0]  dx9, dy9;
  logic signed [13:0] dx14, dy14, x_sum, y_sum;
  logic [11:0] x_new, y_new;

  always_comb begin
    dx9  = x_ovf_reg ? 9'd0 : {x_sign_reg, dx_raw_reg};
    dy9  = y_ovf_reg ? 9'd0 : {y_sign_reg, rx_byte_reg};
    dx14 = {{5{dx9[8]}}, dx9};
    dy14 = {{5{dy9[8]}}, dy9};
    x_sum = $signed({2'b00, x_reg}) + dx14;
    // Mouse-up is positive dY but screen Y grows downwards.
    y_sum = $signed({2'b00, y_reg}) - dy14;
    if (x_sum[13])            x_new = 12'd0;
    else if (x_sum > X_MAX_S) x_new = 12'(X_MAX);
    else                      x_new = x_sum[11:0];
    if (y_sum[13])            y_new = 12'd0;
    else if (y_sum > Y_MAX_S) y_new = 12'(Y_MAX);
    else                      y_new = y_sum[11:0];
  end

  always_ff @(posedge CLK_50MHZ or negedge MASTER_RST) begin
    if (!MASTER_RST) begin
      x_reg         <= 12'(X_INIT);
      y_reg         <= 12'(Y_INIT);
      l_reg         <= 1'b0;
      r_reg         <= 1'b0;
      m_reg         <= 1'b0;
      pkt_valid_reg <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      pkt_valid_reg <= pkt_apply;
      frame_err_reg <= start_err | byte_done_bad | timeout_hit;
      if (pkt_apply) begin
        x_reg <= x_new;
        y_reg <= y_new;
        l_reg <= btn_pend_reg[0];
        r_reg <= btn_pend_reg[1];
        m_reg <= btn_pend_reg[2];
      end
    end
  end

  assign XCOORD    = x_reg;
  assign YCOORD    = y_reg;
  assign L_BUTTON  = l_reg;
  assign R_BUTTON  = r_reg;
  assign M_BUTTON  = m_reg;
  assign PKT_VALID = pkt_valid_reg;
  assign FRAME_ERR = frame_err_reg;

endmodule

// File: tb/tb_ps2_mouse_decoder.sv
`timescale 1ns/1ps
module tb_ps2_mouse_decoder;

  localparam int H = 6;  // system clocks per PS/2 clock half period

  logic        CLK_50MHZ = 1'b0;
  logic        MASTER_RST = 1'b0;
  logic        PS2_CLK = 1'b1;
  logic        PS2_DATA = 1'b1;
  logic [11:0] XCOORD, YCOORD;
  logic        L_BUTTON, R_BUTTON, M_BUTTON, PKT_VALID, FRAME_ERR;

  int tests_run = 0;
  int tests_failed = 0;
  int pkt_seen = 0;
  int err_seen = 0;

  // Reference model state
  int mx, my;
  bit ml, mr, mm;

  always #10 CLK_50MHZ = ~CLK_50MHZ;

  ps2_mouse_decoder dut (
    .CLK_50MHZ (CLK_50MHZ),
    .MASTER_RST(MASTER_RST),
    .PS2_CLK   (PS2_CLK),
    .PS2_DATA  (PS2_DATA),
    .XCOORD    (XCOORD),
    .YCOORD    (YCOORD),
    .L_BUTTON  (L_BUTTON),
    .R_BUTTON  (R_BUTTON),
    .M_BUTTON  (M_BUTTON),
    .PKT_VALID (PKT_VALID),
    .FRAME_ERR (FRAME_ERR)
  );

  always @(negedge CLK_50MHZ) begin
    if (PKT_VALID === 1'b1) pkt_seen++;
    if (FRAME_ERR === 1'b1) err_seen++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  function automatic logic [26:0] exp_state();
    return {12'(mx), 12'(my), ml, mr, mm};
  endfunction

  function automatic logic [26:0] got_state();
    return {XCOORD, YCOORD, L_BUTTON, R_BUTTON, M_BUTTON};
  endfunction

  task automatic model_reset();
    mx = 320; my = 240; ml = 0; mr = 0; mm = 0;
  endtask

  task automatic model_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int dx, dy;
    dx = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
    dy = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
    mx = clampi(mx + dx, 639);
    my = clampi(my - dy, 479);
    ml = b0[0]; mr = b0[1]; mm = b0[2];
  endtask

  // ---------------- PS/2 device driver ----------------
  task automatic ps2_bit(input logic b);
    @(negedge CLK_50MHZ) PS2_DATA = b;
    repeat (H) @(negedge CLK_50MHZ);
    PS2_CLK = 1'b0;
    repeat (H) @(negedge CLK_50MHZ);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic flip_par, input logic bad_stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit((~^d) ^ flip_par);
    ps2_bit(~bad_stop);
    PS2_DATA = 1'b1;
    repeat (20) @(negedge CLK_50MHZ);
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b0, 1'b0);
    send_byte(b1, 1'b0, 1'b0);
    send_byte(b2, 1'b0, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    MASTER_RST = 1'b0;
    model_reset();
    repeat (5) @(negedge CLK_50MHZ);
    tests_run++;
    if (got_state() !== exp_state() || PKT_VALID !== 1'b0 || FRAME_ERR !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_hold: got state=%h pv=%b fe=%b expected state=%h pv=0 fe=0",
               got_state(), PKT_VALID, FRAME_ERR, exp_state());
    end
    MASTER_RST = 1'b1;
    repeat (50) @(negedge CLK_50MHZ);
    tests_run++;
    if (pkt_seen !== 0 || err_seen !== 0 || got_state() !== exp_state()) begin
      tests_failed++;
      $display("FAIL reset_release: got pkts=%0d errs=%0d state=%h expected 0 0 %h",
               pkt_seen, err_seen, got_state(), exp_state());
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_basic();
    int p0;
    p0 = pkt_seen;
    send_packet(8'h09, 8'h05, 8'h03);
    model_packet(8'h09, 8'h05, 8'h03);
    tests_run++;
    if (XCOORD !== 12'd325 || YCOORD !== 12'd237) begin
      tests_failed++;
      $display("FAIL basic_xy: got x=%0d y=%0d expected x=325 y=237", XCOORD, YCOORD);
    end
    tests_run++;
    if ({L_BUTTON, R_BUTTON, M_BUTTON} !== 3'b100 || pkt_seen - p0 !== 1) begin
      tests_failed++;
      $display("FAIL basic_btn: got lrm=%b%b%b pkts=%0d expected lrm=100 pkts=1",
               L_BUTTON, R_BUTTON, M_BUTTON, pkt_seen - p0);
    end
    $display("[TB] test_basic pkt 09 05 03 -> x=%0d y=%0d", XCOORD, YCOORD);
  endtask

  task automatic test_clamp();
    // Walk X to 630 and Y to 400, then push both past their limits.
    send_packet(8'h08, 8'h7F, 8'h00); model_packet(8'h08, 8'h7F, 8'h00);
    send_packet(8'h08, 8'h7F, 8'h00); model_packet(8'h08, 8'h7F, 8'h00);
    send_packet(8'h08, 8'h33, 8'h00); model_packet(8'h08, 8'h33, 8'h00);
    send_packet(8'h28, 8'h00, 8'h80); model_packet(8'h28, 8'h00, 8'h80);
    send_packet(8'h28, 8'h00, 8'hDD); model_packet(8'h28, 8'h00, 8'hDD);
    tests_run++;
    if (got_state() !== exp_state() || XCOORD !== 12'd630 || YCOORD !== 12'd400) begin
      tests_failed++;
      $display("FAIL clamp_setup: got x=%0d y=%0d expected x=630 y=400", XCOORD, YCOORD);
    end
    send_packet(8'h08, 8'h20, 8'h00); model_packet(8'h08, 8'h20, 8'h00);
    tests_run++;
    if (XCOORD !== 12'd639) begin
      tests_failed++;
      $display("FAIL clamp_xmax: got x=%0d expected 639", XCOORD);
    end
    send_packet(8'h38, 8'h80, 8'h80); model_packet(8'h38, 8'h80, 8'h80);
    tests_run++;
    if (YCOORD !== 12'd479 || XCOORD !== 12'd511) begin
      tests_failed++;
      $display("FAIL clamp_ymax: got x=%0d y=%0d expected x=511 y=479", XCOORD, YCOORD);
    end
    $display("[TB] test_clamp -> x=%0d y=%0d", XCOORD, YCOORD);
  endtask

  task automatic test_parity_err();
    int p0, e0;
    p0 = pkt_seen; e0 = err_seen;
    send_byte(8'h08, 1'b0, 1'b0);
    send_byte(8'h05, 1'b1, 1'b0);
    repeat (20) @(negedge CLK_50MHZ);
    tests_run++;
    if (err_seen - e0 !== 1 || pkt_seen - p0 !== 0) begin
      tests_failed++;
      $display("FAIL parity_err: got errs=%0d pkts=%0d expected errs=1 pkts=0",
               err_seen - e0, pkt_seen - p0);
    end
    send_packet(8'h0C, 8'hF0, 8'h10); model_packet(8'h0C, 8'hF0, 8'h10);
    tests_run++;
    if (got_state() !== exp_state() || pkt_seen - p0 !== 1) begin
      tests_failed++;
      $display("FAIL parity_recover: got state=%h pkts=%0d expected state=%h pkts=1",
               got_state(), pkt_seen - p0, exp_state());
    end
    $display("[TB] test_parity_err -> x=%0d y=%0d", XCOORD, YCOORD);
  endtask

  task automatic test_framing_err();
    int p0, e0;
    p0 = pkt_seen; e0 = err_seen;
    ps2_bit(1'b1);                  // falling edge with data high in idle
    repeat (20) @(negedge CLK_50MHZ);
    send_byte(8'h09, 1'b0, 1'b1);   // bad stop bit
    tests_run++;
    if (err_seen - e0 !== 2 || pkt_seen - p0 !== 0) begin
      tests_failed++;
      $display("FAIL start_stop_err: got errs=%0d pkts=%0d expected errs=2 pkts=0",
               err_seen - e0, pkt_seen - p0);
    end
    $display("[TB] test_framing_err errs=%0d", err_seen - e0);
  endtask

  task automatic test_resync();
    int p0, e0;
    p0 = pkt_seen; e0 = err_seen;
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'hFA, 1'b0, 1'b0);   // ACK is dropped too
    send_packet(8'h0A, 8'h01, 8'h01); model_packet(8'h0A, 8'h01, 8'h01);
    tests_run++;
    if (got_state() !== exp_state() || R_BUTTON !== 1'b1) begin
      tests_failed++;
      $display("FAIL resync_state: got state=%h expected %h", got_state(), exp_state());
    end
    tests_run++;
    if (pkt_seen - p0 !== 1 || err_seen - e0 !== 0) begin
      tests_failed++;
      $display("FAIL resync_pulses: got pkts=%0d errs=%0d expected 1 0",
               pkt_seen - p0, err_seen - e0);
    end
    $display("[TB] test_resync -> x=%0d y=%0d", XCOORD, YCOORD);
  endtask

  task automatic test_timeout();
    int p0, e0;
    p0 = pkt_seen; e0 = err_seen;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    PS2_DATA = 1'b1;
    repeat (50100) @(negedge CLK_50MHZ);
    tests_run++;
    if (err_seen - e0 !== 1 || pkt_seen - p0 !== 0) begin
      tests_failed++;
      $display("FAIL timeout_err: got errs=%0d pkts=%0d expected errs=1 pkts=0",
               err_seen - e0, pkt_seen - p0);
    end
    send_packet(8'h19, 8'hFB, 8'h07); model_packet(8'h19, 8'hFB, 8'h07);
    tests_run++;
    if (got_state() !== exp_state() || pkt_seen - p0 !== 1 || err_seen - e0 !== 1) begin
      tests_failed++;
      $display("FAIL timeout_recover: got state=%h pkts=%0d expected state=%h pkts=1",
               got_state(), pkt_seen - p0, exp_state());
    end
    $display("[TB] test_timeout -> x=%0d y=%0d", XCOORD, YCOORD);
  endtask

  task automatic test_overflow();
    int p0, x0, y0;
    p0 = pkt_seen; x0 = mx; y0 = my;
    send_packet(8'h48, 8'hFF, 8'h02); model_packet(8'h48, 8'hFF, 8'h02);
    tests_run++;
    if (int'(XCOORD) !== x0 || int'(YCOORD) !== clampi(y0 - 2, 479) || pkt_seen - p0 !== 1) begin
      tests_failed++;
      $display("FAIL overflow: got x=%0d y=%0d pkts=%0d expected x=%0d y=%0d pkts=1",
               XCOORD, YCOORD, pkt_seen - p0, x0, clampi(y0 - 2, 479));
    end
    $display("[TB] test_overflow -> x=%0d y=%0d", XCOORD, YCOORD);
  endtask

  task automatic test_reset_mid();
    send_byte(8'h0F, 1'b0, 1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    @(negedge CLK_50MHZ) MASTER_RST = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK_50MHZ);
    tests_run++;
    if (got_state() !== exp_state()) begin
      tests_failed++;
      $display("FAIL reset_mid: got state=%h expected %h", got_state(), exp_state());
    end
    PS2_DATA = 1'b1;
    MASTER_RST = 1'b1;
    repeat (10) @(negedge CLK_50MHZ);
    send_packet(8'h0A, 8'h10, 8'hF0); model_packet(8'h0A, 8'h10, 8'hF0);
    tests_run++;
    if (got_state() !== exp_state()) begin
      tests_failed++;
      $display("FAIL reset_mid_recover: got state=%h expected %h", got_state(), exp_state());
    end
    $display("[TB] test_reset_mid -> x=%0d y=%0d", XCOORD, YCOORD);
  endtask

  task automatic test_random();
    logic [7:0] b0, b1, b2;
    int p0;
    for (int n = 0; n < 12; n++) begin
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      b0[3] = 1'b1;
      if ($urandom_range(3) != 0) b0[7:6] = 2'b00;  // keep overflow occasional
      if (b0 == 8'hFA) b0 = 8'h0A;
      p0 = pkt_seen;
      send_packet(b0, b1, b2);
      model_packet(b0, b1, b2);
      tests_run++;
      if (got_state() !== exp_state() || pkt_seen - p0 !== 1) begin
        tests_failed++;
        $display("FAIL random_%0d pkt %h %h %h: got state=%h pkts=%0d expected state=%h pkts=1",
                 n, b0, b1, b2, got_state(), pkt_seen - p0, exp_state());
      end
      $display("[TB] random pkt %h %h %h -> x=%0d y=%0d lrm=%b%b%b",
               b0, b1, b2, XCOORD, YCOORD, L_BUTTON, R_BUTTON, M_BUTTON);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_parity_err();
    test_framing_err();
    test_resync();
    test_overflow();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
